// File: rtl/distribuidor_entrada_pkg.sv
// Shared definitions for the input-FIFO distributor and the switch arbiter:
// destination field layout, FIFO count, holding-stage state encoding.
package distribuidor_entrada_pkg;

    localparam int DATA_W_DEFAULT = 6;
    localparam int NUM_FIFOS      = 4;
    localparam int DEST_W         = 2;
    localparam int DEST_HI        = DATA_W_DEFAULT - 1;
    localparam int DEST_LO        = DATA_W_DEFAULT - DEST_W;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_e;

endpackage

// File: rtl/distribuidor_entrada_contador_sat.sv
// Saturating up-counter used for the per-FIFO push and stall statistics.
// Holds at all-ones instead of wrapping; cleared by synchronous active-low reset.
module contador_sat #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step by one unless already at the ceiling.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/distribuidor_entrada.sv
// Write-side front end for the four arbiter input FIFOs. A one-entry holding
// stage takes words from the source, routes each by its class field to one
// FIFO while respecting that FIFO's almost-full, and keeps push/stall stats.
module distribuidor_entrada
    import distribuidor_entrada_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              afull0,
    input  logic              afull1,
    input  logic              afull2,
    input  logic              afull3,
    output logic              push0_out,
    output logic              push1_out,
    output logic              push2_out,
    output logic              push3_out,
    output logic [DATA_W-1:0] fifo_data_out,
    output logic              idle,
    output logic [CNT_W-1:0]  push_cnt0,
    output logic [CNT_W-1:0]  push_cnt1,
    output logic [CNT_W-1:0]  push_cnt2,
    output logic [CNT_W-1:0]  push_cnt3,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;

    logic [NUM_FIFOS-1:0] afull;
    logic [NUM_FIFOS-1:0] push_vec;
    logic [DEST_W-1:0]    tgt;
    logic                 fire;
    logic                 accept;
    logic                 stall_inc;
    logic [CNT_W-1:0]     push_cnt [NUM_FIFOS];

    assign afull = {afull3, afull2, afull1, afull0};
    assign tgt   = hold_data_q[DATA_W-1 -: DEST_W];

    // Handshake and routing: push the held word unless its own FIFO is almost full;
    // accept a new word whenever the stage is empty or is being emptied this cycle.
    always_comb begin
        push_vec  = '0;
        fire      = reset && (state_q == LOADED) && !afull[tgt];
        in_ready  = reset && ((state_q == EMPTY) || fire);
        accept    = in_valid && in_ready;
        stall_inc = reset && (state_q == LOADED) && afull[tgt];
        if (fire) begin
            push_vec[tgt] = 1'b1;
        end
    end

    // Holding-stage next state; data is only captured on accept, so in_data
    // garbage while in_valid is low never reaches the stage.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = LOADED;
                    hold_data_d = in_data;
                end
            end
            LOADED: begin
                if (accept) begin
                    hold_data_d = in_data;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Holding-stage registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
        end
    end

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_push_cnt
        contador_sat #(.CNT_W(CNT_W)) u_push_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (push_vec[i]),
            .count (push_cnt[i])
        );
    end

    contador_sat #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    assign push0_out     = push_vec[0];
    assign push1_out     = push_vec[1];
    assign push2_out     = push_vec[2];
    assign push3_out     = push_vec[3];
    assign fifo_data_out = hold_data_q;
    assign idle          = (state_q == EMPTY);
    assign push_cnt0     = push_cnt[0];
    assign push_cnt1     = push_cnt[1];
    assign push_cnt2     = push_cnt[2];
    assign push_cnt3     = push_cnt[3];

endmodule

// File: tb/tb_distribuidor_entrada.sv
// Bench for distribuidor_entrada: directed scenarios plus a random phase.
// Accepted words go into an in-order expected queue; a negedge monitor
// predicts handshake, routing and counters from that queue and compares.
module tb_distribuidor_entrada;
    import distribuidor_entrada_pkg::*;

    localparam int DW  = DATA_W_DEFAULT;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    afull_v = '0;
    logic          in_ready;
    logic          push0_out, push1_out, push2_out, push3_out;
    logic [DW-1:0] fifo_data_out;
    logic          idle;
    logic [CW-1:0] push_cnt0, push_cnt1, push_cnt2, push_cnt3, stall_cnt;

    distribuidor_entrada #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .afull0        (afull_v[0]),
        .afull1        (afull_v[1]),
        .afull2        (afull_v[2]),
        .afull3        (afull_v[3]),
        .push0_out     (push0_out),
        .push1_out     (push1_out),
        .push2_out     (push2_out),
        .push3_out     (push3_out),
        .fifo_data_out (fifo_data_out),
        .idle          (idle),
        .push_cnt0     (push_cnt0),
        .push_cnt1     (push_cnt1),
        .push_cnt2     (push_cnt2),
        .push_cnt3     (push_cnt3),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_q[$];        // accepted, not yet pushed, in order
    int            m_push_cnt[4];
    int            m_stall_cnt;
    bit            started = 1'b0;

    logic [1:0]    m_dest;
    bit            m_fire, m_ready;
    logic [3:0]    m_push_exp;

    always @(negedge clk) begin
        if (started) begin
            m_dest     = (exp_q.size() > 0) ? exp_q[0][DEST_HI:DEST_LO] : 2'd0;
            m_fire     = reset && (exp_q.size() > 0) && !afull_v[m_dest];
            m_ready    = reset && ((exp_q.size() == 0) || m_fire);
            m_push_exp = m_fire ? (4'b0001 << m_dest) : 4'b0000;

            check("in_ready", in_ready, m_ready);
            check("push_vec", {push3_out, push2_out, push1_out, push0_out}, m_push_exp);
            check("idle", idle, exp_q.size() == 0);
            if (exp_q.size() > 0) check("fifo_data", fifo_data_out, exp_q[0]);
            check("push_cnt0", push_cnt0, m_push_cnt[0]);
            check("push_cnt1", push_cnt1, m_push_cnt[1]);
            check("push_cnt2", push_cnt2, m_push_cnt[2]);
            check("push_cnt3", push_cnt3, m_push_cnt[3]);
            check("stall_cnt", stall_cnt, m_stall_cnt);

            // Advance the model to what the coming rising edge will do.
            if (!reset) begin
                exp_q.delete();
                foreach (m_push_cnt[i]) m_push_cnt[i] = 0;
                m_stall_cnt = 0;
            end else begin
                if (exp_q.size() > 0 && afull_v[m_dest] && m_stall_cnt < SAT) m_stall_cnt++;
                if (m_fire) begin
                    void'(exp_q.pop_front());
                    if (m_push_cnt[m_dest] < SAT) m_push_cnt[m_dest]++;
                end
                if (in_valid && m_ready) exp_q.push_back(in_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word and hold it until the handshake edge; returns 1 ns after it.
    task automatic send(input logic [DW-1:0] w);
        bit rdy;
        int waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    // Two reset cycles with in_valid held high, which must be ignored.
    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        tick(1);
        started  = 1'b1;
        tick(1);
        reset    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] w;
    bit            rand_on;

    initial begin
        afull_v = '0;
        do_reset();

        // Routing: one word per FIFO, back-to-back.
        send(6'b00_0001);
        send(6'b01_0010);
        send(6'b10_0011);
        send(6'b11_0100);
        tick(3);
        check("route_cnt0", push_cnt0, 1);
        check("route_cnt1", push_cnt1, 1);
        check("route_cnt2", push_cnt2, 1);
        check("route_cnt3", push_cnt3, 1);

        // Stall on FIFO 2; afull0 must not matter.
        do_reset();
        afull_v = 4'b0101;
        send(6'b10_1010);
        tick(3);
        check("stall3_cnt", stall_cnt, 3);
        afull_v = 4'b0000;
        @(negedge clk);
        check("stall_release_push2", push2_out, 1'b1);
        check("stall_release_data", fifo_data_out, 6'b10_1010);
        tick(1);
        check("stall_release_cnt2", push_cnt2, 1);

        // Ordering: A (dest 1) stalled while B (dest 0) waits.
        do_reset();
        afull_v = 4'b0010;
        send(6'b01_1100);
        fork
            send(6'b00_0110);
            begin
                tick(4);
                afull_v = 4'b0000;
            end
        join
        tick(3);
        check("order_cnt0", push_cnt0, 1);
        check("order_cnt1", push_cnt1, 1);

        // Reset while loaded and pushable: no push, word discarded.
        do_reset();
        send(6'b11_0111);
        reset    = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("midreset_push3", push3_out, 1'b0);
        tick(1);
        reset    = 1'b1;
        in_valid = 1'b0;
        tick(3);
        check("midreset_cnt3", push_cnt3, 0);
        check("midreset_idle", idle, 1'b1);

        // Saturation of push_cnt0 and stall_cnt.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            w = {2'b00, 4'(i)};
            send(w);
        end
        tick(2);
        check("sat_push_cnt0", push_cnt0, SAT);
        afull_v = 4'b0001;
        send(6'b00_1111);
        tick(10);
        check("sat_stall_cnt", stall_cnt, SAT);
        afull_v = 4'b0000;
        tick(2);

        // Random traffic with random almost-full pattern.
        do_reset();
        rand_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    tick($urandom_range(0, 2));
                    w = DW'($urandom);
                    send(w);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    afull_v = 4'($urandom & $urandom);
                    tick(1);
                end
            end
        join
        afull_v = 4'b0000;
        tick(4);
        check("final_idle", idle, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
